// File: rtl/gray_pkg.sv
// gray_pkg: shared widths, tracking state and Gray/binary conversion helpers
package gray_pkg;
    localparam int W_DEF = 32;
    localparam int CNT_W_DEF = 16;
    localparam int G_MAX = 64;
    typedef enum logic {EMPTY, TRACKING} track_e;
    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [G_MAX-1:0] gray2bin(input logic [G_MAX-1:0] g);
        logic [G_MAX-1:0] b;
        b[G_MAX-1] = g[G_MAX-1];
        for (int i = G_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    function automatic logic [G_MAX-1:0] bin2gray(input logic [G_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/popcount_w.sv
// popcount_w: combinational count of set bits in a W-bit word
// a_i: input word; cnt_o: number of ones, $clog2(W)+1 bits
module popcount_w #(
    parameter int W = 32
) (
    input  logic [W-1:0]       a_i,
    output logic [$clog2(W):0] cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) cnt_o = cnt_o + ($clog2(W)+1)'(a_i[i]);
    end
endmodule

// File: rtl/gray_monitor.sv
// gray_monitor: decodes a Gray counter stream and checks it steps by exactly +1
// clk/reset: clock, sync active-high reset; g/g_valid: Gray sample and qualifier
// bin/bin_valid: decoded value two edges later; err_pulse/err_sticky/err_count: step errors
// toggle_count: summed Hamming distance between valid samples; sample_count: accepted samples
module gray_monitor
    import gray_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter bit ALLOW_HOLD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     g,
    input  logic             g_valid,
    output logic [W-1:0]     bin,
    output logic             bin_valid,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] sample_count
);
    localparam int PW = $clog2(W) + 1;
    // toggle sum is wide enough for both the counter and a full-width Hamming distance
    localparam int SW = (CNT_W > PW ? CNT_W : PW) + 1;
    logic [W-1:0] g_q, bin_q, g_prev_q, bin_prev_q, dec;
    logic v1_q, bin_valid_q, err_pulse_q, err_sticky_q, step_ok, err;
    logic [CNT_W-1:0] err_count_q, toggle_count_q, sample_count_q, toggle_count_d;
    logic [PW-1:0] hd;
    logic [SW-1:0] tsum;
    track_e state_q, state_d;
    popcount_w #(.W(W)) u_pc (.a_i(g_q ^ g_prev_q), .cnt_o(hd));
    assign dec = W'(gray2bin(G_MAX'(g_q)));
    always_comb begin
        step_ok = dec == bin_prev_q + W'(1);
        err = v1_q && state_q == TRACKING &&
              (hd > PW'(1) || (hd == PW'(1) && !step_ok) || (hd == '0 && !ALLOW_HOLD));
        tsum = SW'(toggle_count_q) + SW'(hd);
        toggle_count_d = tsum > SW'({CNT_W{1'b1}}) ? '1 : tsum[CNT_W-1:0];
        state_d = v1_q ? TRACKING : state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q <= '0;
            v1_q <= 1'b0;
            bin_q <= '0;
            bin_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q <= '0;
            toggle_count_q <= '0;
            sample_count_q <= '0;
            g_prev_q <= '0;
            bin_prev_q <= '0;
            state_q <= EMPTY;
        end else begin
            g_q <= g;
            v1_q <= g_valid;
            bin_valid_q <= v1_q;
            err_pulse_q <= err;
            state_q <= state_d;
            if (v1_q) begin
                bin_q <= dec;
                g_prev_q <= g_q;
                bin_prev_q <= dec;
                sample_count_q <= sample_count_q + CNT_W'(sample_count_q != '1);
                if (state_q == TRACKING) toggle_count_q <= toggle_count_d;
            end
            if (err) begin
                err_sticky_q <= 1'b1;
                err_count_q <= err_count_q + CNT_W'(err_count_q != '1);
            end
        end
    end
    assign bin = bin_q;
    assign bin_valid = bin_valid_q;
    assign err_pulse = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count = err_count_q;
    assign toggle_count = toggle_count_q;
    assign sample_count = sample_count_q;
endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor: directed checks of decode latency, step errors, gaps, wrap, hold and saturation
module tb_gray_monitor;
    logic clk, reset, g_valid;
    logic [31:0] g;
    logic [31:0] bin, bin_h, bin_s;
    logic bin_valid, bin_valid_h, bin_valid_s;
    logic err_pulse, err_pulse_h, err_pulse_s;
    logic err_sticky, err_sticky_h, err_sticky_s;
    logic [15:0] err_count, toggle_count, sample_count;
    logic [15:0] err_count_h, toggle_count_h, sample_count_h;
    logic [3:0] err_count_s, toggle_count_s, sample_count_s;
    int checks = 0;
    int failures = 0;

    gray_monitor dut (
        .clk(clk), .reset(reset), .g(g), .g_valid(g_valid),
        .bin(bin), .bin_valid(bin_valid), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_count(err_count), .toggle_count(toggle_count), .sample_count(sample_count)
    );
    gray_monitor #(.ALLOW_HOLD(1'b1)) dut_h (
        .clk(clk), .reset(reset), .g(g), .g_valid(g_valid),
        .bin(bin_h), .bin_valid(bin_valid_h), .err_pulse(err_pulse_h), .err_sticky(err_sticky_h),
        .err_count(err_count_h), .toggle_count(toggle_count_h), .sample_count(sample_count_h)
    );
    gray_monitor #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .g(g), .g_valid(g_valid),
        .bin(bin_s), .bin_valid(bin_valid_s), .err_pulse(err_pulse_s), .err_sticky(err_sticky_s),
        .err_count(err_count_s), .toggle_count(toggle_count_s), .sample_count(sample_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs change on the falling edge; outputs seen here reflect the sample driven two ticks earlier
    task automatic tick(input logic [31:0] gv, input logic v);
        @(negedge clk);
        g = gv;
        g_valid = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        g_valid = 1'b0;
        g = '0;
        @(negedge clk);
        chk("rst_bin", bin, 0);
        chk("rst_bin_valid", bin_valid, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_toggle_count", toggle_count, 0);
        chk("rst_sample_count", sample_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        g = '0;
        g_valid = 1'b0;
        do_reset();
        tick(0, 1);
        tick(1, 1);
        tick(3, 1);
        chk("seq_bin0", bin, 0);
        chk("seq_valid0", bin_valid, 1);
        tick(2, 1);
        chk("seq_bin1", bin, 1);
        tick(6, 1);
        chk("seq_bin2", bin, 2);
        tick(0, 0);
        chk("seq_bin3", bin, 3);
        tick(0, 0);
        chk("seq_bin4", bin, 4);
        chk("seq_err_count", err_count, 0);
        chk("seq_toggle", toggle_count, 4);
        chk("seq_samples", sample_count, 5);
        tick(0, 0);
        chk("seq_gap_valid", bin_valid, 0);
        chk("seq_gap_hold", bin, 4);

        do_reset();
        tick(0, 1);
        tick(1, 1);
        tick(3, 1);
        tick(6, 1);
        tick(0, 0);
        chk("hd2_no_pulse_early", err_pulse, 0);
        tick(0, 0);
        chk("hd2_bin", bin, 4);
        chk("hd2_pulse", err_pulse, 1);
        chk("hd2_sticky", err_sticky, 1);
        chk("hd2_count", err_count, 1);
        chk("hd2_toggle", toggle_count, 4);
        tick(0, 0);
        chk("hd2_pulse_drop", err_pulse, 0);
        chk("hd2_sticky_hold", err_sticky, 1);

        do_reset();
        tick(3, 1);
        tick(2, 1);
        tick(3, 1);
        chk("bwd_first_bin", bin, 2);
        tick(0, 0);
        chk("fwd_bin", bin, 3);
        chk("fwd_no_err", err_pulse, 0);
        tick(0, 0);
        chk("bwd_bin", bin, 2);
        chk("bwd_pulse", err_pulse, 1);
        chk("bwd_count", err_count, 1);
        chk("bwd_toggle", toggle_count, 2);
        chk("bwd_samples", sample_count, 3);

        do_reset();
        tick(32'h8000_0000, 1);
        tick(32'h0000_0000, 1);
        tick(0, 0);
        chk("wrap_max", bin, 32'hFFFF_FFFF);
        tick(0, 0);
        chk("wrap_zero", bin, 0);
        chk("wrap_pulse", err_pulse, 0);
        chk("wrap_count", err_count, 0);
        chk("wrap_toggle", toggle_count, 1);

        do_reset();
        tick(5, 1);
        tick(5, 1);
        tick(0, 0);
        tick(0, 0);
        chk("hold_bin", bin, 6);
        chk("hold_err_pulse", err_pulse, 1);
        chk("hold_err_count", err_count, 1);
        chk("hold_ok_pulse", err_pulse_h, 0);
        chk("hold_ok_count", err_count_h, 0);
        chk("hold_ok_toggle", toggle_count_h, 0);

        do_reset();
        tick(1, 1);
        tick(0, 0);
        tick(3, 1);
        chk("gap_first_bin", bin, 1);
        tick(0, 0);
        chk("gap_valid", bin_valid, 0);
        chk("gap_hold", bin, 1);
        chk("gap_pulse", err_pulse, 0);
        tick(0, 0);
        chk("gap_next_bin", bin, 2);
        chk("gap_next_pulse", err_pulse, 0);
        chk("gap_err_count", err_count, 0);
        chk("gap_toggle", toggle_count, 1);
        chk("gap_samples", sample_count, 2);

        do_reset();
        tick(0, 1);
        tick(1, 1);
        tick(3, 1);
        do_reset();
        tick(32'h1234, 1);
        tick(0, 0);
        tick(0, 0);
        chk("post_rst_bin", bin, 32'h1C27);
        chk("post_rst_pulse", err_pulse, 0);
        chk("post_rst_count", err_count, 0);
        chk("post_rst_toggle", toggle_count, 0);
        chk("post_rst_samples", sample_count, 1);

        do_reset();
        repeat (21) tick(5, 1);
        tick(0, 0);
        tick(0, 0);
        chk("sat_err_count", err_count_s, 15);
        chk("sat_samples", sample_count_s, 15);
        chk("sat_sticky", err_sticky_s, 1);
        chk("nosat_err_count", err_count, 20);
        chk("nosat_samples", sample_count, 21);
        chk("sat_hold_count", err_count_h, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
